mem_mmio_ctrl: RTL and testbench

MEM_MMIO_CTRL -- requirements
Module: mem_mmio_ctrl

---
 rtl/mem_mmio_ctrl.sv | 110 +++++++++++
 tb/tb_mem_mmio_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_mmio_ctrl.sv
// Memory/MMIO controller: single-port word RAM plus memory-mapped output registers.
// Writes complete in one cycle; reads return one cycle after acceptance through an RD state.
module mem_mmio_ctrl #(
  parameter int unsigned RAM_DEPTH = 256,
  parameter int unsigned NUM_OUT   = 2,
  parameter int unsigned OUT_W     = 16,
  parameter logic [31:0] OUT_BASE  = 32'h0001_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req,
  input  logic                     we,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic                     ready,
  output logic [31:0]              rdata,
  output logic                     rvalid,
  output logic                     err,
  output logic [NUM_OUT*OUT_W-1:0] out_ports
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned OW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic {IDLE, RD} state_t;

  state_t           state;
  logic [31:0]      mem [RAM_DEPTH];
  logic [OUT_W-1:0] out_regs [NUM_OUT];

  logic          ram_hit;
  logic          out_hit;
  logic [OW-1:0] out_idx;
  logic [AW-1:0] ram_idx;
  logic [31:0]   out_rd;
  logic          accept;

  // ready drops combinationally while reset is held so nothing is accepted then
  assign ready  = rst_n && (state == IDLE);
  assign accept = req && ready;

  // Address decode: RAM region at the bottom, output registers at OUT_BASE
  always_comb begin
    out_hit = 1'b0;
    out_idx = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (addr == OUT_BASE + 32'(4 * i)) begin
        out_hit = 1'b1;
        out_idx = OW'(i);
      end
    end
    ram_hit = (addr[1:0] == 2'b00) && ((addr >> (AW + 2)) == 32'd0);
    ram_idx = addr[2 +: AW];
    out_rd  = out_hit ? 32'(out_regs[out_idx]) : 32'd0;
  end

  // RAM storage is never reset
  always_ff @(posedge clk) begin
    if (accept && we && ram_hit) begin
      mem[ram_idx] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= 32'd0;
      for (int i = 0; i < int'(NUM_OUT); i++) begin
        out_regs[i] <= '0;
      end
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= 32'd0;
      case (state)
        IDLE: begin
          if (req) begin
            if (we) begin
              if (out_hit) begin
                out_regs[out_idx] <= wdata[OUT_W-1:0];
              end else if (!ram_hit) begin
                err <= 1'b1;
              end
            end else begin
              // Illegal reads still complete with rvalid so the core is never stalled
              state  <= RD;
              rvalid <= 1'b1;
              if (ram_hit) begin
                rdata <= mem[ram_idx];
              end else if (out_hit) begin
                rdata <= out_rd;
              end else begin
                err <= 1'b1;
              end
            end
          end
        end
        RD:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    assign out_ports[g*OUT_W +: OUT_W] = out_regs[g];
  end

endmodule

// File: tb/tb_mem_mmio_ctrl.sv
// Directed self-checking bench for mem_mmio_ctrl with default parameters.
module tb_mem_mmio_ctrl;

  localparam int unsigned RAM_DEPTH = 256;
  localparam int unsigned NUM_OUT   = 2;
  localparam int unsigned OUT_W     = 16;
  localparam logic [31:0] OUT_BASE  = 32'h0001_0000;

  logic                     clk;
  logic                     rst_n;
  logic                     req;
  logic                     we;
  logic [31:0]              addr;
  logic [31:0]              wdata;
  logic                     ready;
  logic [31:0]              rdata;
  logic                     rvalid;
  logic                     err;
  logic [NUM_OUT*OUT_W-1:0] out_ports;

  int checks;
  int failures;

  mem_mmio_ctrl #(
    .RAM_DEPTH(RAM_DEPTH),
    .NUM_OUT  (NUM_OUT),
    .OUT_W    (OUT_W),
    .OUT_BASE (OUT_BASE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .err      (err),
    .out_ports(out_ports)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    tick();
    tick();
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++;
    if (rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) begin
      failures++; $display("FAIL reset_outs rvalid=%b err=%b rdata=%h exp 0/0/0", rvalid, err, rdata);
    end
    checks++;
    if (out_ports !== 32'd0) begin failures++; $display("FAIL reset_out_ports got=%h exp=0", out_ports); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", ready); end
  endtask

  task automatic test_ram_wr_rd();
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (err !== 1'b0 || ready !== 1'b1) begin
      failures++; $display("FAIL ram_wr_status err=%b ready=%b exp err=0 ready=1", err, ready);
    end
    we = 1'b0;
    tick();
    req = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ram_rd rvalid=%b rdata=%h exp 1/deadbeef", rvalid, rdata);
    end
    checks++;
    if (ready !== 1'b0 || err !== 1'b0) begin
      failures++; $display("FAIL ram_rd_status ready=%b err=%b exp 0/0", ready, err);
    end
    tick();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'd0 || ready !== 1'b1) begin
      failures++; $display("FAIL ram_rd_after rvalid=%b rdata=%h ready=%b exp 0/0/1", rvalid, rdata, ready);
    end
  endtask

  task automatic test_out_reg();
    req = 1'b1; we = 1'b1; addr = OUT_BASE + 32'd4; wdata = 32'h1234_ABCD;
    tick();
    req = 1'b0;
    checks++;
    if (out_ports !== 32'hABCD_0000) begin
      failures++; $display("FAIL out_write got=%h exp=abcd0000", out_ports);
    end
    req = 1'b1; we = 1'b0;
    tick();
    req = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h0000_ABCD || err !== 1'b0) begin
      failures++; $display("FAIL out_read rvalid=%b rdata=%h err=%b exp 1/0000abcd/0", rvalid, rdata, err);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [31:0] bad_addr [4];
    bad_addr[0] = 32'h13;
    bad_addr[1] = 32'd4 * RAM_DEPTH;
    bad_addr[2] = OUT_BASE + 32'd8;
    bad_addr[3] = OUT_BASE + 32'd2;
    req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h1111_1111;
    tick();
    wdata = 32'hFFFF_FFFF;
    foreach (bad_addr[i]) begin
      addr = bad_addr[i];
      tick();
      checks++;
      if (err !== 1'b1 || ready !== 1'b1) begin
        failures++; $display("FAIL illegal_wr_%0d err=%b ready=%b exp 1/1", i, err, ready);
      end
    end
    req = 1'b0;
    tick();
    checks++;
    if (err !== 1'b0 || out_ports !== 32'hABCD_0000) begin
      failures++; $display("FAIL illegal_after err=%b out_ports=%h exp 0/abcd0000", err, out_ports);
    end
    req = 1'b1; we = 1'b0; addr = 32'h0002_0000;
    tick();
    req = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'd0 || err !== 1'b1) begin
      failures++; $display("FAIL illegal_rd rvalid=%b rdata=%h err=%b exp 1/0/1", rvalid, rdata, err);
    end
    tick();
    checks++;
    if (err !== 1'b0 || rvalid !== 1'b0) begin
      failures++; $display("FAIL illegal_rd_after err=%b rvalid=%b exp 0/0", err, rvalid);
    end
    req = 1'b1; addr = 32'h10;
    tick();
    req = 1'b0;
    checks++;
    if (rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL illegal_ram10 got=%h exp=deadbeef", rdata); end
    tick();
    req = 1'b1; addr = 32'h0;
    tick();
    req = 1'b0;
    checks++;
    if (rdata !== 32'h1111_1111) begin failures++; $display("FAIL illegal_ram0 got=%h exp=11111111", rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'hA000_0000;
    exp_data[1] = 32'hA111_1111;
    exp_data[2] = 32'hA222_2222;
    exp_data[3] = 32'hA333_3333;
    req = 1'b1; we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(4 * i); wdata = exp_data[i];
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, ready); end
      tick();
    end
    // Reads with req held high: the request stays asserted through the RD cycle
    we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(4 * i);
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_data[i] || ready !== 1'b0) begin
        failures++;
        $display("FAIL b2b_rd_%0d rvalid=%b rdata=%h ready=%b exp 1/%h/0", i, rvalid, rdata, ready, exp_data[i]);
      end
      tick();
      checks++;
      if (rvalid !== 1'b0 || rdata !== 32'd0) begin
        failures++; $display("FAIL b2b_gap_%0d rvalid=%b rdata=%h exp 0/0", i, rvalid, rdata);
      end
    end
    req = 1'b0;
    // A write held during RD must be ignored
    req = 1'b1; addr = 32'h8;
    tick();
    we = 1'b1; wdata = 32'h0000_0BAD;
    tick();
    req = 1'b0; we = 1'b0;
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL rd_ignore_err got=%b exp=0", err); end
    req = 1'b1; addr = 32'h8;
    tick();
    req = 1'b0;
    checks++;
    if (rdata !== exp_data[2]) begin failures++; $display("FAIL rd_ignore_data got=%h exp=%h", rdata, exp_data[2]); end
    tick();
  endtask

  task automatic test_reset_in_rd();
    req = 1'b1; we = 1'b0; addr = 32'h0;
    tick();
    req = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'd0 || ready !== 1'b0) begin
      failures++; $display("FAIL rst_rd rvalid=%b rdata=%h ready=%b exp 0/0/0", rvalid, rdata, ready);
    end
    checks++;
    if (out_ports !== 32'd0) begin failures++; $display("FAIL rst_rd_out got=%h exp=0", out_ports); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL rst_rd_ready got=%b exp=1", ready); end
    tick();
    checks++;
    if (rvalid !== 1'b0) begin failures++; $display("FAIL rst_rd_no_rvalid got=%b exp=0", rvalid); end
    req = 1'b1; addr = 32'h0;
    tick();
    req = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'hA000_0000) begin
      failures++; $display("FAIL rst_ram_keep rvalid=%b rdata=%h exp 1/a0000000", rvalid, rdata);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_ram_wr_rd();
    test_out_reg();
    test_illegal();
    test_back_to_back();
    test_reset_in_rd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
